// File: rtl/andrewm_uart_pkg.sv
package andrewm_uart_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE     = 2'b00,
    MODE_LOAD_LSB = 2'b01,
    MODE_LOAD_MSB = 2'b10,
    MODE_SEND     = 2'b11
  } mode_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

endpackage

// File: rtl/andrewm_sync_fifo.sv
module andrewm_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == (AW+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/andrewm_uart_tx_fifo.sv
module andrewm_uart_tx_fifo
  import andrewm_uart_pkg::*;
#(
  parameter int unsigned NIB_W        = 4,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NIB_W-1:0] nib_in,
  input  logic [1:0]       mode,
  output logic             uart_tx,
  output logic             busy,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             overflow
);

  localparam int unsigned DATA_W = 2 * NIB_W;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(DATA_W - 1);

  mode_e mode_in;
  assign mode_in = mode_e'(mode);

  logic [NIB_W-1:0]  lsb_q, lsb_d;
  mode_e             prev_mode_q, prev_mode_d;
  logic              overflow_q, overflow_d;
  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              stop_q, stop_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;

  logic              push, pop;
  logic [DATA_W-1:0] fifo_rdata;
  logic              baud_done, last_stop;

  andrewm_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({nib_in, lsb_q}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    lsb_d = lsb_q;
    if (mode_in == MODE_LOAD_LSB) lsb_d = nib_in;
    prev_mode_d = mode_in;
    push = (mode_in == MODE_LOAD_MSB) && (prev_mode_q != MODE_LOAD_MSB);
    overflow_d = overflow_q;
    if (mode_in == MODE_IDLE)      overflow_d = 1'b0;
    else if (push && fifo_full)    overflow_d = 1'b1;
  end

  assign baud_done = (baud_q == '0);
  assign last_stop = (STOP_BITS < 2) || stop_q;
  assign pop       = (state_q == S_IDLE) && (mode_in == MODE_SEND) && !fifo_empty;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (pop) state_d = S_START;
      S_START:  if (baud_done) state_d = S_DATA;
      S_DATA:   if (baud_done && (bit_q == LAST_BIT))
                  state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
      S_PARITY: if (baud_done) state_d = S_STOP;
      S_STOP:   if (baud_done && last_stop) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // tx_d is taken from the next-cycle datapath values so the line
  // register changes on exactly the same edge as the state.
  always_comb begin
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    stop_d   = stop_q;
    if (state_q == S_IDLE) begin
      if (pop) begin
        shift_d  = fifo_rdata;
        parity_d = (PARITY == PAR_EVEN) ? ^fifo_rdata : ~(^fifo_rdata);
        baud_d   = BAUD_RELOAD;
        bit_d    = '0;
        stop_d   = 1'b0;
      end
    end else if (baud_done) begin
      baud_d = BAUD_RELOAD;
      if ((state_q == S_DATA) && (state_d == S_DATA)) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + BIT_W'(1);
      end
      if ((state_q == S_STOP) && (state_d == S_STOP)) stop_d = 1'b1;
    end else begin
      baud_d = baud_q - BAUD_W'(1);
    end

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lsb_q       <= '0;
      prev_mode_q <= MODE_IDLE;
      overflow_q  <= 1'b0;
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      stop_q      <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      lsb_q       <= lsb_d;
      prev_mode_q <= prev_mode_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      stop_q      <= stop_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
    end
  end

  assign uart_tx  = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_andrewm_uart_tx_fifo.sv
module tb_andrewm_uart_tx_fifo;
  import andrewm_uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] nib;
  logic [1:0] mode;
  logic [2:0] tx_w, busy_w, full_w, empty_w, ovf_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // dut0: no parity, 1 stop; dut1: even parity, 2 stops; dut2: odd parity, 1 stop
  andrewm_uart_tx_fifo #(.NIB_W(4), .CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .nib_in(nib), .mode(mode), .uart_tx(tx_w[0]), .busy(busy_w[0]),
    .fifo_full(full_w[0]), .fifo_empty(empty_w[0]), .overflow(ovf_w[0]));
  andrewm_uart_tx_fifo #(.NIB_W(4), .CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .nib_in(nib), .mode(mode), .uart_tx(tx_w[1]), .busy(busy_w[1]),
    .fifo_full(full_w[1]), .fifo_empty(empty_w[1]), .overflow(ovf_w[1]));
  andrewm_uart_tx_fifo #(.NIB_W(4), .CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(1)) dut2 (
    .clk(clk), .reset(reset), .nib_in(nib), .mode(mode), .uart_tx(tx_w[2]), .busy(busy_w[2]),
    .fifo_full(full_w[2]), .fifo_empty(empty_w[2]), .overflow(ovf_w[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int par_of(input int i);
    return (i == 1) ? 1 : (i == 2) ? 2 : 0;
  endfunction

  function automatic int stop_of(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  function automatic int flen(input int i);
    return (1 + 8 + ((par_of(i) != 0) ? 1 : 0) + stop_of(i)) * 4;
  endfunction

  function automatic logic exp_bit(input int i, input logic [7:0] d, input int c);
    int seg;
    seg = c / 4;
    if (seg == 0) return 1'b0;
    if (seg <= 8) return d[seg-1];
    if ((seg == 9) && (par_of(i) != 0)) return (par_of(i) == 1) ? ^d : ~(^d);
    return 1'b1;
  endfunction

  task automatic push_word(input logic [7:0] w);
    mode = MODE_LOAD_LSB; nib = w[3:0]; tick();
    mode = MODE_LOAD_MSB; nib = w[7:4]; tick();
  endtask

  // Entered one cycle after the pop edge; returns in the first idle cycle
  // of the longest selected frame.
  task automatic check_frames(input logic [7:0] d, input logic [2:0] mask, input int idle_at);
    int maxlen;
    maxlen = 0;
    for (int i = 0; i < 3; i++)
      if (mask[i] && (flen(i) > maxlen)) maxlen = flen(i);
    for (int c = 0; c <= maxlen; c++) begin
      if (c == idle_at) mode = MODE_IDLE;
      for (int i = 0; i < 3; i++) begin
        if (mask[i]) begin
          if (c < flen(i)) begin
            chk($sformatf("tx_d%0d_%02h_c%0d", i, d, c), 8'(tx_w[i]), 8'(exp_bit(i, d, c)));
            if (c == 0) chk($sformatf("busy_start_d%0d", i), 8'(busy_w[i]), 8'd1);
          end else if (c == flen(i)) begin
            chk($sformatf("tx_idle_d%0d", i), 8'(tx_w[i]), 8'd1);
            chk($sformatf("busy_idle_d%0d", i), 8'(busy_w[i]), 8'd0);
          end
        end
      end
      if (c < maxlen) tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    mode  = MODE_IDLE;
    nib   = 4'h0;
    tick();
    tick();

    // 1: asynchronous reset
    #2 reset = 1'b0;
    #1;
    chk("rst_tx",    8'(tx_w[0]),    8'd1);
    chk("rst_busy",  8'(busy_w[0]),  8'd0);
    chk("rst_empty", 8'(empty_w[0]), 8'd1);
    chk("rst_full",  8'(full_w[0]),  8'd0);
    chk("rst_ovf",   8'(ovf_w[0]),   8'd0);
    tick();
    reset = 1'b1;
    tick();

    // 2: single word 0xA5, held LOAD_MSB pushes once
    mode = MODE_LOAD_LSB; nib = 4'h5; tick();
    mode = MODE_LOAD_MSB; nib = 4'hA; tick();
    chk("t2_not_empty", 8'(empty_w[0]), 8'd0);
    repeat (9) tick();
    chk("t2_not_full", 8'(full_w[0]), 8'd0);
    mode = MODE_SEND;
    tick();
    chk("t2_empty_after_pop", 8'(empty_w[0]), 8'd1);
    check_frames(8'hA5, 3'b001, -1);
    tick();
    chk("t2_no_second_tx",   8'(tx_w[0]),   8'd1);
    chk("t2_no_second_busy", 8'(busy_w[0]), 8'd0);

    // 3: fill, overflow, back-to-back drain
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    chk("t3_full_at3", 8'(full_w[0]), 8'd0);
    push_word(8'h44);
    chk("t3_full_at4", 8'(full_w[0]), 8'd1);
    chk("t3_ovf_at4",  8'(ovf_w[0]),  8'd0);
    push_word(8'h55);
    chk("t3_ovf_at5",  8'(ovf_w[0]),  8'd1);
    chk("t3_full_at5", 8'(full_w[0]), 8'd1);
    mode = MODE_SEND;
    tick();
    check_frames(8'h11, 3'b001, -1);
    tick();
    check_frames(8'h22, 3'b001, -1);
    tick();
    check_frames(8'h33, 3'b001, -1);
    tick();
    check_frames(8'h44, 3'b001, -1);
    tick();
    chk("t3_drained_tx",    8'(tx_w[0]),    8'd1);
    chk("t3_drained_busy",  8'(busy_w[0]),  8'd0);
    chk("t3_drained_empty", 8'(empty_w[0]), 8'd1);
    chk("t3_ovf_held",      8'(ovf_w[0]),   8'd1);
    mode = MODE_IDLE;
    tick();
    chk("t3_ovf_cleared", 8'(ovf_w[0]), 8'd0);

    // 4: parity and stop-bit variants, word 0x07
    reset = 1'b0; tick(); reset = 1'b1; tick();
    push_word(8'h07);
    mode = MODE_SEND;
    tick();
    check_frames(8'h07, 3'b111, -1);

    // 5: leave SEND mid-frame, then reset mid-frame
    mode = MODE_IDLE;
    reset = 1'b0; tick(); reset = 1'b1; tick();
    push_word(8'hFF);
    push_word(8'h3C);
    push_word(8'h5A);
    mode = MODE_SEND;
    tick();
    check_frames(8'hFF, 3'b001, 17);
    chk("t5_word_kept", 8'(empty_w[0]), 8'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t5_no_pop_tx_%0d", k),   8'(tx_w[0]),   8'd1);
      chk($sformatf("t5_no_pop_busy_%0d", k), 8'(busy_w[0]), 8'd0);
    end
    mode = MODE_SEND;
    tick();
    repeat (10) tick();
    chk("t5_mid_busy",  8'(busy_w[0]),  8'd1);
    chk("t5_mid_tx",    8'(tx_w[0]),    8'(exp_bit(0, 8'h3C, 10)));
    chk("t5_mid_empty", 8'(empty_w[0]), 8'd0);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_tx",    8'(tx_w[0]),    8'd1);
    chk("t5_rst_busy",  8'(busy_w[0]),  8'd0);
    chk("t5_rst_empty", 8'(empty_w[0]), 8'd1);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("t5_quiet_tx_%0d", k),   8'(tx_w[0]),   8'd1);
      chk($sformatf("t5_quiet_busy_%0d", k), 8'(busy_w[0]), 8'd0);
    end
    push_word(8'h81);
    mode = MODE_SEND;
    tick();
    check_frames(8'h81, 3'b001, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
